// File: rtl/mem_pkg.sv
// Memory-operation encodings and decode shared by the core, the address decoder and the data RAM.
// One decode function keeps the store-width and load-extension rules in a single place.
package mem_pkg;

    localparam logic [2:0] MEMOP_LB  = 3'b000;
    localparam logic [2:0] MEMOP_LH  = 3'b001;
    localparam logic [2:0] MEMOP_LW  = 3'b010;
    localparam logic [2:0] MEMOP_LBU = 3'b100;
    localparam logic [2:0] MEMOP_LHU = 3'b101;

    typedef enum logic [1:0] {
        ACC_BYTE = 2'd0,
        ACC_HALF = 2'd1,
        ACC_WORD = 2'd2,
        ACC_NONE = 2'd3
    } acc_width_e;

    typedef struct packed {
        acc_width_e width;
        logic       sign_ext;
    } memop_dec_t;

    function automatic memop_dec_t decode_memop(input logic [2:0] op);
        memop_dec_t d;
        d.width    = ACC_NONE;
        d.sign_ext = 1'b0;
        case (op)
            MEMOP_LB:  begin d.width = ACC_BYTE; d.sign_ext = 1'b1; end
            MEMOP_LH:  begin d.width = ACC_HALF; d.sign_ext = 1'b1; end
            MEMOP_LW:  d.width = ACC_WORD;
            MEMOP_LBU: d.width = ACC_BYTE;
            MEMOP_LHU: d.width = ACC_HALF;
            default:   d.width = ACC_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter: picks the addressed byte/half out of a raw word and
// sign- or zero-extends it; word and invalid ops pass the full word through.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  offset,
    input  logic [2:0]  memop,
    output logic [31:0] value
);

    memop_dec_t  dec;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        dec       = decode_memop(memop);
        lane_byte = raw[{offset, 3'b000} +: 8];
        lane_half = offset[1] ? raw[31:16] : raw[15:0];
        value     = raw;
        case (dec.width)
            ACC_BYTE: value = {{24{dec.sign_ext & lane_byte[7]}}, lane_byte};
            ACC_HALF: value = {{16{dec.sign_ext & lane_half[15]}}, lane_half};
            default:  value = raw;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Single-clock, word-organised data RAM with per-byte write enables and a registered,
// read-first read port; the load result is formatted after the read register.
module data_memory
    import mem_pkg::*;
#(
    parameter int    ADDR_WIDTH = 17,
    parameter string INIT_FILE  = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic [2:0]  memop,
    input  logic        we,
    output logic [31:0] dataout
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] widx;
    memop_dec_t            dec;
    logic [3:0]            be;
    logic [31:0]           wdata;

    logic [31:0] rd_word;
    logic [1:0]  rd_off;
    logic [2:0]  rd_op;

    logic unused_bits;
    assign unused_bits = ^{addr[31:ADDR_WIDTH+2], dec.sign_ext};

    assign widx = addr[ADDR_WIDTH+1:2];

    // Store data is replicated across lanes so each byte enable just picks its own lane.
    always_comb begin
        dec   = decode_memop(memop);
        be    = 4'b0000;
        wdata = datain;
        case (dec.width)
            ACC_BYTE: begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{datain[7:0]}};
            end
            ACC_HALF: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{datain[15:0]}};
            end
            ACC_WORD: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
        if (!we) be = 4'b0000;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Non-blocking read of the array alongside the write gives read-first behaviour.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_word <= 32'h0;
            rd_off  <= 2'b00;
            rd_op   <= MEMOP_LW;
        end else begin
            rd_word <= mem[widx];
            rd_off  <= addr[1:0];
            rd_op   <= memop;
        end
    end

    load_extend u_load_extend (
        .raw    (rd_word),
        .offset (rd_off),
        .memop  (rd_op),
        .value  (dataout)
    );

endmodule

// File: tb/tb_data_memory.sv
// Directed and randomized checks of data_memory against a byte-addressed reference model.
module tb_data_memory;

    localparam int AW = 17;
    localparam int unsigned WMASK = (1 << AW) - 1;

    logic        clock;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] datain;
    logic [2:0]  memop;
    logic        we;
    logic [31:0] dataout;

    int checks;
    int errors;

    logic [7:0] m_bytes [int unsigned];

    data_memory #(.ADDR_WIDTH(AW), .INIT_FILE("")) dut (
        .clock   (clock),
        .reset   (reset),
        .addr    (addr),
        .datain  (datain),
        .memop   (memop),
        .we      (we),
        .dataout (dataout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int unsigned base_of(input logic [31:0] a);
        return ((a >> 2) & WMASK) * 4;
    endfunction

    function automatic logic [7:0] m_byte(input int unsigned ba);
        if (m_bytes.exists(ba)) return m_bytes[ba];
        return 8'hxx;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] op);
        int unsigned b;
        int unsigned bo;
        int          v;
        b = base_of(a);
        case (op)
            3'b000, 3'b100: begin
                v = int'(m_byte(b + a[1:0]));
                if (op == 3'b000 && v >= 128) v = v - 256;
                return 32'(v);
            end
            3'b001, 3'b101: begin
                bo = b + (a[1] ? 2 : 0);
                v = int'(m_byte(bo)) + 256 * int'(m_byte(bo + 1));
                if (op == 3'b001 && v >= 32768) v = v - 65536;
                return 32'(v);
            end
            default: return {m_byte(b + 3), m_byte(b + 2), m_byte(b + 1), m_byte(b)};
        endcase
    endfunction

    function automatic void m_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
        int unsigned b;
        b = base_of(a);
        case (op)
            3'b000, 3'b100: m_bytes[b + a[1:0]] = d[7:0];
            3'b001, 3'b101: begin
                m_bytes[b + (a[1] ? 2 : 0)] = d[7:0];
                m_bytes[b + (a[1] ? 3 : 1)] = d[15:8];
            end
            3'b010: for (int i = 0; i < 4; i++) m_bytes[b + i] = d[8*i +: 8];
            default: ;
        endcase
    endfunction

    // One clock of stimulus; the expected read value comes from the model before this cycle's write.
    task automatic cycle(input logic rst_n, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] op, input logic w, input bit chk,
                         input bit use_const, input logic [31:0] exp_const, input string tag);
        logic [31:0] exp;
        exp = rst_n ? m_load(a, op) : 32'h0;
        if (use_const && exp !== exp_const) begin
            errors++;
            $error("FAIL model_%s: model %h constant %h", tag, exp, exp_const);
        end
        if (use_const) exp = exp_const;
        if (rst_n && w) m_store(a, d, op);
        @(negedge clock);
        reset  = rst_n;
        addr   = a;
        datain = d;
        memop  = op;
        we     = w;
        @(posedge clock);
        #1;
        if (chk) begin
            checks++;
            assert (dataout === exp)
            else begin
                errors++;
                $error("FAIL %s: got %h expected %h", tag, dataout, exp);
            end
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rd;
        logic [2:0]  rop;
        logic        rw;
        logic        rr;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        addr   = 32'h0;
        datain = 32'h0;
        memop  = 3'b010;
        we     = 1'b0;

        cycle(1'b0, 32'h0, 32'h0, 3'b010, 1'b0, 1, 1, 32'h0, "reset_init_a");
        cycle(1'b0, 32'h0, 32'h0, 3'b010, 1'b1, 1, 1, 32'h0, "reset_init_b");

        cycle(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 1'b1, 0, 0, 32'h0, "sw_100");
        cycle(1'b1, 32'h100, 32'h0, 3'b010, 1'b0, 1, 1, 32'hDEADBEEF, "lw_100");

        cycle(1'b1, 32'h100, 32'h0, 3'b010, 1'b1, 1, 1, 32'hDEADBEEF, "sw0_100_prev");
        cycle(1'b1, 32'h101, 32'h7F, 3'b000, 1'b1, 1, 1, 32'h0, "sb_101_prev");
        cycle(1'b1, 32'h100, 32'h0, 3'b010, 1'b0, 1, 1, 32'h00007F00, "lw_after_sb");
        cycle(1'b1, 32'h101, 32'h0, 3'b000, 1'b0, 1, 1, 32'h0000007F, "lb_101");
        cycle(1'b1, 32'h103, 32'hFFA5, 3'b000, 1'b1, 1, 1, 32'h0, "sb_103_prev");
        cycle(1'b1, 32'h103, 32'h0, 3'b100, 1'b0, 1, 1, 32'h000000A5, "lbu_103");
        cycle(1'b1, 32'h103, 32'h0, 3'b000, 1'b0, 1, 1, 32'hFFFFFFA5, "lb_103");
        cycle(1'b1, 32'h100, 32'h0, 3'b010, 1'b0, 1, 1, 32'hA5007F00, "lw_lane3");
        cycle(1'b1, 32'h102, 32'h0, 3'b101, 1'b0, 1, 1, 32'h0000A500, "lhu_102");

        cycle(1'b1, 32'h200, 32'h80FF8001, 3'b010, 1'b1, 0, 0, 32'h0, "sw_200");
        cycle(1'b1, 32'h200, 32'h0, 3'b000, 1'b0, 1, 1, 32'h00000001, "lb_200");
        cycle(1'b1, 32'h201, 32'h0, 3'b000, 1'b0, 1, 1, 32'hFFFFFF80, "lb_201");
        cycle(1'b1, 32'h201, 32'h0, 3'b100, 1'b0, 1, 1, 32'h00000080, "lbu_201");
        cycle(1'b1, 32'h202, 32'h0, 3'b001, 1'b0, 1, 1, 32'hFFFF80FF, "lh_202");
        cycle(1'b1, 32'h202, 32'h0, 3'b101, 1'b0, 1, 1, 32'h000080FF, "lhu_202");

        cycle(1'b1, 32'h300, 32'hAAAAAAAA, 3'b010, 1'b1, 0, 0, 32'h0, "sw_300");
        cycle(1'b1, 32'h303, 32'h00001234, 3'b001, 1'b1, 1, 1, 32'hFFFFAAAA, "sh_303_prev");
        cycle(1'b1, 32'h300, 32'h0, 3'b010, 1'b0, 1, 1, 32'h1234AAAA, "lw_after_sh");

        cycle(1'b1, 32'h400, 32'h11, 3'b010, 1'b1, 0, 0, 32'h0, "sw_400");
        cycle(1'b1, 32'h400, 32'h55, 3'b010, 1'b1, 1, 1, 32'h00000011, "rdw_old");
        cycle(1'b1, 32'h400, 32'h0, 3'b010, 1'b0, 1, 1, 32'h00000055, "rdw_new");

        cycle(1'b1, 32'h500, 32'h0BADF00D, 3'b010, 1'b1, 0, 0, 32'h0, "sw_500");
        cycle(1'b0, 32'h500, 32'hFFFFFFFF, 3'b010, 1'b1, 1, 1, 32'h0, "reset_write");
        cycle(1'b1, 32'h500, 32'h0, 3'b010, 1'b0, 1, 1, 32'h0BADF00D, "lw_after_reset");
        cycle(1'b1, 32'h500, 32'h12345678, 3'b111, 1'b1, 1, 1, 32'h0BADF00D, "inv_111");
        cycle(1'b1, 32'h501, 32'h12345678, 3'b110, 1'b1, 1, 1, 32'h0BADF00D, "inv_110");
        cycle(1'b1, 32'h502, 32'h0, 3'b011, 1'b0, 1, 1, 32'h0BADF00D, "inv_011_read");

        cycle(1'b1, 32'h00080104, 32'hCAFEF00D, 3'b010, 1'b1, 0, 0, 32'h0, "sw_wrap");
        cycle(1'b1, 32'h104, 32'h0, 3'b010, 1'b0, 1, 1, 32'hCAFEF00D, "lw_wrap_low");
        cycle(1'b1, 32'hFFF80104, 32'h0, 3'b010, 1'b0, 1, 1, 32'hCAFEF00D, "lw_wrap_high");

        for (int i = 0; i < 16; i++)
            cycle(1'b1, 32'h800 + 32'(4 * i), $urandom, 3'b010, 1'b1, 0, 0, 32'h0, "rnd_init");

        for (int i = 0; i < 300; i++) begin
            ra  = 32'h800 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 4) == 0) ra = ra | (32'($urandom_range(1, 8191)) << 19);
            rd  = $urandom;
            rop = 3'($urandom_range(0, 7));
            rw  = 1'($urandom_range(0, 1));
            rr  = ($urandom_range(0, 19) != 0);
            cycle(rr, ra, rd, rop, rw, 1, 0, 32'h0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
